// File: rtl/segment7_decoder_if.sv
// segment7_decoder_if: groups the digit inputs, override controls and the
// error-monitor outputs of one seven-segment digit.
// master = digit-select / mux side, slave = the decoder itself.
interface segment7_decoder_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       bcd;
  logic             lamp_test;
  logic             blank;
  logic             err_clr;
  logic [6:0]       seg;
  logic             invalid;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output bcd, lamp_test, blank, err_clr,
    input  seg, invalid, err_sticky, err_cnt
  );

  modport slave (
    input  bcd, lamp_test, blank, err_clr,
    output seg, invalid, err_sticky, err_cnt
  );
endinterface

// File: rtl/segment7_decoder.sv
// segment7_decoder: BCD to seven-segment decoder for one display digit.
// Segment order on seg is a..g from bit 6 down to bit 0.
// The decode path is combinational. Codes 10-15 show a dash and raise
// invalid.
// A clocked monitor keeps a sticky flag and a saturating count of the
// clock edges on which invalid was high.
// Optional macro SEG7_REG_OUT_EN registers seg and invalid. This adds one
// cycle of latency, and reset then drives the display dark. The error
// monitor then follows the registered invalid.
// The CNT_W of the interface instance must match the CNT_W of this module.
module segment7_decoder #(
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  segment7_decoder_if.slave bus
);

  // Segment patterns in common-anode sense (0 = lit).
  localparam logic [6:0] SEG_ALL_LIT  = 7'b0000000;
  localparam logic [6:0] SEG_ALL_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH     = 7'b1111110;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       table_seg;
  logic [6:0]       prio_seg;
  logic [6:0]       drive_seg;
  logic             bad_code;
  logic             err_src;
  logic             err_sticky_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Full decode table. The default arm covers 10-15 and unknown codes,
  // so this logic never holds an old value.
  always_comb begin
    table_seg = SEG_DASH;
    case (bus.bcd)
      4'd0:    table_seg = 7'b0000001;
      4'd1:    table_seg = 7'b1001111;
      4'd2:    table_seg = 7'b0010010;
      4'd3:    table_seg = 7'b0000110;
      4'd4:    table_seg = 7'b1001100;
      4'd5:    table_seg = 7'b0100100;
      4'd6:    table_seg = 7'b0100000;
      4'd7:    table_seg = 7'b0001111;
      4'd8:    table_seg = 7'b0000000;
      4'd9:    table_seg = 7'b0000100;
      default: table_seg = SEG_DASH;
    endcase
  end

  // Override priority: lamp test beats blanking, and blanking beats the
  // decoded digit.
  always_comb begin
    prio_seg = table_seg;
    if (bus.lamp_test) begin
      prio_seg = SEG_ALL_LIT;
    end else if (bus.blank) begin
      prio_seg = SEG_ALL_DARK;
    end
  end

  // A common-cathode display gets the final vector inverted.
  // The inversion is applied after the override mux.
  assign drive_seg = (ACTIVE_LOW != 0) ? prio_seg : ~prio_seg;

  // A non-BCD code is flagged whatever the override inputs are.
  assign bad_code = (bus.bcd > 4'd9);

`ifdef SEG7_REG_OUT_EN
  localparam logic [6:0] DARK_DRIVE = (ACTIVE_LOW != 0) ? SEG_ALL_DARK : ~SEG_ALL_DARK;

  logic [6:0] seg_q;
  logic       invalid_q;

  // Output register: the display goes dark and invalid clears during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= DARK_DRIVE;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= drive_seg;
      invalid_q <= bad_code;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.invalid = invalid_q;
  assign err_src     = invalid_q;
`else
  assign bus.seg     = drive_seg;
  assign bus.invalid = bad_code;
  assign err_src     = bad_code;
`endif

  // Error monitor. A clear has priority over an invalid code on the same
  // edge. The count saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (bus.err_clr) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (err_src) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_q <= err_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_segment7_decoder.sv
// tb_segment7_decoder: self-checking bench for segment7_decoder.
// Works with or without SEG7_REG_OUT_EN. Inputs change on the falling
// edge. Outputs are sampled on the next falling edge, or 1 ns after the
// drive for the zero-latency check.
`timescale 1ns/1ps
module tb_segment7_decoder;

  typedef struct {
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;
    logic [6:0] exp_seg;
    logic       exp_inv;
  } vec_t;

  typedef struct {
    int         idx;
    logic [6:0] seg;
    logic       inv;
  } exp_t;

  localparam int NV = 21;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  exp_t sb[$];
  vec_t vecs[NV];

  // 10 ns clock.
  always #5 clk = ~clk;

  segment7_decoder_if #(.CNT_W(8)) dec_if ();

  segment7_decoder #(
    .ACTIVE_LOW(1),
    .CNT_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dec_if)
  );

  // Drive the digit inputs and record the response the decoder should give.
  task automatic applyStimulus(input int idx, input logic [3:0] b, input logic lt,
                               input logic bl, input logic [6:0] es, input logic ei);
    exp_t e;
    dec_if.bcd       = b;
    dec_if.lamp_test = lt;
    dec_if.blank     = bl;
    e.idx = idx;
    e.seg = es;
    e.inv = ei;
    sb.push_back(e);
  endtask

  // Generic compare of one observed value against its expected value.
  task automatic checkBits(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with seg and invalid.
  task automatic checkOutput(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, seg=%b invalid=%b", name, dec_if.seg, dec_if.invalid);
    end else begin
      e = sb.pop_front();
      checkBits($sformatf("%s[%0d].seg", name, e.idx), {1'b0, dec_if.seg}, {1'b0, e.seg});
      checkBits($sformatf("%s[%0d].invalid", name, e.idx), {7'b0, dec_if.invalid}, {7'b0, e.inv});
    end
  endtask

  task automatic checkErr(input string name, input logic es, input logic [7:0] ec);
    checkBits({name, ".err_sticky"}, {7'b0, dec_if.err_sticky}, {7'b0, es});
    checkBits({name, ".err_cnt"}, dec_if.err_cnt, ec);
  endtask

  // Stop a runaway simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence.
  initial begin
    vecs[0]  = '{4'd0,  1'b0, 1'b0, 7'b0000001, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 1'b0, 7'b1001111, 1'b0};
    vecs[2]  = '{4'd2,  1'b0, 1'b0, 7'b0010010, 1'b0};
    vecs[3]  = '{4'd3,  1'b0, 1'b0, 7'b0000110, 1'b0};
    vecs[4]  = '{4'd4,  1'b0, 1'b0, 7'b1001100, 1'b0};
    vecs[5]  = '{4'd5,  1'b0, 1'b0, 7'b0100100, 1'b0};
    vecs[6]  = '{4'd6,  1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[7]  = '{4'd7,  1'b0, 1'b0, 7'b0001111, 1'b0};
    vecs[8]  = '{4'd8,  1'b0, 1'b0, 7'b0000000, 1'b0};
    vecs[9]  = '{4'd9,  1'b0, 1'b0, 7'b0000100, 1'b0};
    vecs[10] = '{4'd10, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[11] = '{4'd11, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[12] = '{4'd12, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[13] = '{4'd13, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[14] = '{4'd14, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[15] = '{4'd15, 1'b0, 1'b0, 7'b1111110, 1'b1};
    vecs[16] = '{4'd4,  1'b1, 1'b0, 7'b0000000, 1'b0};
    vecs[17] = '{4'd4,  1'b1, 1'b1, 7'b0000000, 1'b0};
    vecs[18] = '{4'd4,  1'b0, 1'b1, 7'b1111111, 1'b0};
    vecs[19] = '{4'd12, 1'b0, 1'b1, 7'b1111111, 1'b1};
    vecs[20] = '{4'd15, 1'b1, 1'b0, 7'b0000000, 1'b1};

    rst              = 1'b1;
    dec_if.bcd       = 4'd0;
    dec_if.lamp_test = 1'b0;
    dec_if.blank     = 1'b0;
    dec_if.err_clr   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkErr("reset", 1'b0, 8'd0);
`ifdef SEG7_REG_OUT_EN
    checkBits("reset.seg_dark", {1'b0, dec_if.seg}, 8'b01111111);
`else
    checkBits("reset.seg_follows", {1'b0, dec_if.seg}, 8'b00000001);
`endif
    rst = 1'b0;

    // Decode table and override priority.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(i, vecs[i].bcd, vecs[i].lamp_test, vecs[i].blank,
                    vecs[i].exp_seg, vecs[i].exp_inv);
      @(negedge clk);
      checkOutput("table");
    end

`ifdef SEG7_REG_OUT_EN
    // The old digit stays visible until the next rising edge.
    applyStimulus(100, 4'd2, 1'b0, 1'b0, 7'b0010010, 1'b0);
    @(negedge clk);
    checkOutput("reg_two");
    applyStimulus(101, 4'd3, 1'b0, 1'b0, 7'b0000110, 1'b0);
    #1;
    checkBits("reg_hold.seg", {1'b0, dec_if.seg}, 8'b00010010);
    @(posedge clk);
    #1;
    checkOutput("reg_three");
`else
    // The decode path has no clock in it.
    applyStimulus(100, 4'd7, 1'b0, 1'b0, 7'b0001111, 1'b0);
    #1;
    checkOutput("zero_latency");
`endif

    // Clear the monitor while the input is a valid code.
    @(negedge clk);
    applyStimulus(200, 4'd3, 1'b0, 1'b0, 7'b0000110, 1'b0);
    dec_if.err_clr = 1'b1;
    @(negedge clk);
    dec_if.err_clr = 1'b0;
    checkOutput("pre_err");
    checkErr("cleared", 1'b0, 8'd0);

    // Three counted edges with code 12 present.
`ifdef SEG7_REG_OUT_EN
    applyStimulus(201, 4'd12, 1'b0, 1'b0, 7'b1111110, 1'b1);
    repeat (4) @(posedge clk);
`else
    applyStimulus(201, 4'd12, 1'b0, 1'b0, 7'b1111110, 1'b1);
    repeat (3) @(posedge clk);
`endif
    @(negedge clk);
    checkOutput("dash12");
    checkErr("count3", 1'b1, 8'd3);

    // Saturation: 300 edges with code 15 held.
    applyStimulus(202, 4'd15, 1'b0, 1'b0, 7'b1111110, 1'b1);
    repeat (251) @(posedge clk);
    @(negedge clk);
    checkErr("count254", 1'b1, 8'd254);
    repeat (1) @(posedge clk);
    @(negedge clk);
    checkErr("count255", 1'b1, 8'd255);
    repeat (48) @(posedge clk);
    @(negedge clk);
    checkOutput("dash15");
    checkErr("saturated", 1'b1, 8'd255);

    // A clear wins over an invalid code on the same edge.
    applyStimulus(203, 4'd10, 1'b0, 1'b0, 7'b1111110, 1'b1);
    dec_if.err_clr = 1'b1;
    @(negedge clk);
    checkErr("clr_priority", 1'b0, 8'd0);
    dec_if.err_clr = 1'b0;
    checkOutput("dash10");

    // Counting resumes, then a reset pulse arrives in the middle of the count.
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkErr("recount4", 1'b1, 8'd4);
    rst = 1'b1;
`ifdef SEG7_REG_OUT_EN
    applyStimulus(204, 4'd5, 1'b0, 1'b0, 7'b1111111, 1'b0);
`else
    applyStimulus(204, 4'd5, 1'b0, 1'b0, 7'b0100100, 1'b0);
    #1;
    checkBits("rst_decode.seg", {1'b0, dec_if.seg}, 8'b00100100);
`endif
    @(negedge clk);
    checkOutput("in_reset");
    checkErr("mid_reset", 1'b0, 8'd0);
    rst = 1'b0;
    applyStimulus(205, 4'd5, 1'b0, 1'b0, 7'b0100100, 1'b0);
    @(negedge clk);
    checkOutput("post_reset");
    checkErr("post_reset", 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/segment7_decoder.md
Name: segment7_decoder

Overview:
- BCD-to-seven-segment decoder for a single common-anode display digit; the segment drive is active-low by default.
- Decode path is combinational, so outputs are zero-latency by default.
- Clocked logic flags and counts invalid (non-BCD) input codes for system health monitoring.
- Sits between the digit-select/mux logic and the display pad drivers.

Parameters:
- ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (common anode); 0 = all segment outputs inverted (common cathode).
- CNT_W, 8, width of the saturating invalid-code counter.

Ports:
- clk  input  1  system clock; only the error-tracking logic, plus the optional output register, uses it.
- rst  input  1  synchronous, active-high reset.
- bcd  input  4  BCD digit to display, 0-9 valid.
- lamp_test  input  1  forces all segments lit.
- blank  input  1  forces all segments dark.
- err_clr  input  1  synchronous clear of err_sticky and err_cnt.
- seg  output  7  segment drive, bit 6 = a, bit 5 = b, bit 4 = c, bit 3 = d, bit 2 = e, bit 1 = f, bit 0 = g.
- invalid  output  1  combinational; high when bcd > 9.
- err_sticky  output  1  registered; set when an invalid code is sampled.
- err_cnt  output  CNT_W  registered saturating count of clock edges with invalid=1.

Behaviour:
- Decode table for ACTIVE_LOW=1, a..g order:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
- Codes 10-15 display a dash (only g lit) = 1111110.
- Output priority:
  - lamp_test=1 gives seg=0000000 (all lit).
  - Otherwise blank=1 gives 1111111 (all dark).
  - Otherwise the decode table applies.
- ACTIVE_LOW=0 inverts the final seg vector bitwise, after the priority mux.
- seg and invalid are purely combinational from their inputs, with zero latency. seg is settled within the same delta; no clock is required for decode.
- invalid = (bcd > 9), independent of lamp_test and blank.
- On each rising clk edge:
  - If rst=1: err_sticky←0 and err_cnt←0.
  - Else if err_clr=1: both are cleared. err_clr has priority over a simultaneous invalid code, so that cycle is not counted.
  - Else if invalid=1: err_sticky←1, and err_cnt increments unless it already equals all-ones (saturates, no wrap).
- Reset values: err_sticky=0, err_cnt=0. seg is not reset in the default build; it follows its inputs even while rst=1.
- X/Z on bcd: the implementation must not latch; synthesis uses a full case with a default.

Optional Feature:
- Macro SEG7_REG_OUT_EN.
- When defined, seg and invalid are registered on clk, giving 1-cycle latency from bcd/lamp_test/blank to the outputs.
  - In this build, reset drives seg to all-dark (1111111 for ACTIVE_LOW=1) and invalid to 0.
  - err_sticky and err_cnt then use the registered invalid, and therefore lag by one further cycle.
- When undefined, the outputs are combinational as described above.

Test Plan:
- Sweep bcd 0..9 with lamp_test=0 and blank=0, waiting 10 time units per step -> seg matches the table exactly, e.g. bcd=0 gives 0000001, bcd=7 gives 0001111, bcd=9 gives 0000100, and invalid=0 throughout.
- bcd=4 with lamp_test=1 -> seg=0000000; then blank=1 together with lamp_test=1 -> still 0000000; then lamp_test=0 -> 1111111.
- bcd=12 -> seg=1111110 and invalid=1; after 3 clocks -> err_sticky=1 and err_cnt=3.
- Hold bcd=15 for 300 clocks with CNT_W=8 -> err_cnt saturates at 255 and does not wrap.
- err_clr=1 asserted for one cycle with bcd=10 -> err_cnt=0 and err_sticky=0 after the edge. Then rst=1 for one cycle mid-count -> both are 0, and seg keeps decoding the current bcd.
- SEG7_REG_OUT_EN build: change bcd from 2 to 3 -> seg shows 0010010 until the next rising edge, then 0000110. During rst, seg=1111111.
